// File: rtl/gray_conv_arbiter_pkg.sv
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared types and the binary-to-Gray conversion function used by
//            the Gray conversion arbiter and the future Gray-to-binary path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

  // Widest word the conversion function handles; callers zero-extend their
  // word into this width and cast the result back to their own width.
  localparam int c_gray_max_w = 64;

  // Output slot occupancy.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // MSB passes through, every lower bit is XOR'd with its upper neighbour.
  // Zero-extension makes the MSB rule fall out of the shift for any width.
  function automatic logic [c_gray_max_w-1:0] bin2gray(input logic [c_gray_max_w-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_conv_arbiter_if.sv
// ============================================================================
// Module   : gray_conv_arbiter_if
// Purpose  : Requester and result handshake bundle of the Gray conversion
//            arbiter. "master" is the client side, "slave" the arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_bin;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_gray;
  logic [WIDTH-1:0]      out_bin;
  logic [IDW-1:0]        out_id;
  logic [15:0]           conv_count;

  modport master (
    output req_valid, req_bin, out_ready,
    input  req_ready, out_valid, out_gray, out_bin, out_id, conv_count
  );

  modport slave (
    input  req_valid, req_bin, out_ready,
    output req_ready, out_valid, out_gray, out_bin, out_id, conv_count
  );

endinterface

`default_nettype wire

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin grant among NREQ requesters. The search starts at
//            the pointer and wraps upward; the pointer moves past the winner
//            only when the grant is actually taken (enable & |req).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] r_rr_ptr;
  logic           w_found;
  logic [IDW-1:0] w_idx;

  // First requester at or after the pointer; IDW-bit addition gives the wrap
  // for free because NREQ is a power of two.
  always_comb begin
    w_found   = 1'b0;
    w_idx     = '0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_rr_ptr + IDW'(k);
      if (!w_found && req[w_idx]) begin
        w_found   = 1'b1;
        grant_idx = w_idx;
      end
    end
    if (w_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer advances to the requester after the winner on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (enable && (|req)) begin
      r_rr_ptr <= grant_idx + IDW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
// ============================================================================
// Module   : gray_conv_arbiter
// Purpose  : Shares one registered binary-to-Gray stage among NREQ
//            requesters. The winner's word is converted and held in a
//            single-entry slot, tagged with its requester index, until the
//            downstream consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  gray_conv_arbiter_if.slave  bus
);

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic             w_slot_free;
  logic             w_xfer;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic [WIDTH-1:0] w_req_words [NREQ];
  logic [WIDTH-1:0] w_sel_bin;
  logic [WIDTH-1:0] r_out_gray;
  logic [WIDTH-1:0] r_out_bin;
  logic [IDW-1:0]   r_out_id;
  logic [15:0]      r_conv_count;

  // Unpack the flat requester bus into one word per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_req_word
    assign w_req_words[i] = bus.req_bin[i*WIDTH +: WIDTH];
  end

  // The slot can take a new word when empty or being drained this cycle.
  // Reset is folded in so no grant is offered while rst is high.
  assign w_slot_free = !rst && ((r_state == EMPTY) || bus.out_ready);
  assign w_xfer      = w_slot_free && (|bus.req_valid);
  assign w_sel_bin   = w_req_words[w_grant_idx];

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .enable    (w_slot_free),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign bus.req_ready = w_grant & {NREQ{w_slot_free}};

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot next state: a transfer always fills it, a drain without refill empties it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = FULL;
    end else if ((r_state == FULL) && bus.out_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  // Result register; data holds its last value after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_gray <= '0;
      r_out_bin  <= '0;
      r_out_id   <= '0;
    end else if (w_xfer) begin
      r_out_gray <= WIDTH'(bin2gray(c_gray_max_w'(w_sel_bin)));
      r_out_bin  <= w_sel_bin;
      r_out_id   <= w_grant_idx;
    end
  end

  // Count of accepted conversions; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conv_count <= '0;
    end else if (w_xfer) begin
      r_conv_count <= r_conv_count + 16'd1;
    end
  end

  assign bus.out_valid  = (r_state == FULL);
  assign bus.out_gray   = r_out_gray;
  assign bus.out_bin    = r_out_bin;
  assign bus.out_id     = r_out_id;
  assign bus.conv_count = r_conv_count;

endmodule

`default_nettype wire
